apb_gpio_slave: RTL and testbench

APB_GPIO_SLAVE -- requirements
Module: apb_gpio_slave

---
 rtl/apb_gpio_slave.sv | 191 +++++++++++++++++++
 tb/tb_apb_gpio_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_slave.sv
// APB slave exposing a GPIO block: output data, direction, synchronised
// input data and rising-edge interrupt status with a level irq.
module apb_gpio_slave #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int WAIT_CYCLES   = 1
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [ADDRESS_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0]    PWDATA,
   input  logic [STRB_WIDTH-1:0]    PSTRB,
   output logic [DATA_WIDTH-1:0]    PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   input  logic [DATA_WIDTH-1:0]    gpio_in,
   output logic [DATA_WIDTH-1:0]    gpio_out,
   output logic [DATA_WIDTH-1:0]    gpio_oe,
   output logic                     irq
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

   localparam logic [1:0] REG_DOUT = 2'd0;
   localparam logic [1:0] REG_DIR  = 2'd1;
   localparam logic [1:0] REG_DIN  = 2'd2;
   localparam logic [1:0] REG_INT  = 2'd3;

   // transfer tracking
   logic [1:0]               state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     write_q, write_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]    strb_q, strb_d;

   // register file and input path
   logic [DATA_WIDTH-1:0]    dout_q, dout_d;
   logic [DATA_WIDTH-1:0]    dir_q, dir_d;
   logic [DATA_WIDTH-1:0]    ists_q, ists_d;
   logic [DATA_WIDTH-1:0]    sync1_q, sync2_q, prev_q;
   logic                     irq_q;

   logic                     in_xfer;
   logic                     access_ready;
   logic                     proto_err;
   logic                     acc_err;
   logic                     done_ok;
   logic                     commit;
   logic [1:0]               reg_sel;
   logic [DATA_WIDTH-1:0]    bmask;
   logic [DATA_WIDTH-1:0]    wbits;
   logic [DATA_WIDTH-1:0]    rise;
   logic [DATA_WIDTH-1:0]    rd_mux;

   assign in_xfer      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign access_ready = PSEL && PENABLE && in_xfer && (cnt_q == WAIT_CNT);
   // PENABLE without a preceding setup phase is rejected immediately
   assign proto_err    = PSEL && PENABLE && (state_q == ST_IDLE);
   assign reg_sel      = addr_q[3:2];
   assign acc_err      = (addr_q[1:0] != 2'b00) || (write_q && (reg_sel == REG_DIN));
   assign done_ok      = access_ready && !acc_err;
   assign commit       = done_ok && write_q;
   assign wbits        = wdata_q & bmask;
   assign rise         = sync2_q & ~prev_q;

   // expand latched byte strobes into a bit mask
   always_comb begin
      bmask = '0;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         bmask[b*8 +: 8] = {8{strb_q[b]}};
      end
   end

   // read mux over the latched address
   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_DOUT: rd_mux = dout_q;
         REG_DIR:  rd_mux = dir_q;
         REG_DIN:  rd_mux = sync2_q;
         REG_INT:  rd_mux = ists_q;
         default:  rd_mux = '0;
      endcase
   end

   // bus outputs, forced quiet while reset is asserted
   always_comb begin
      PREADY  = PRESETn && (access_ready || proto_err);
      PSLVERR = PRESETn && ((access_ready && acc_err) || proto_err);
      PRDATA  = (PRESETn && done_ok && !write_q) ? rd_mux : '0;
   end

   assign gpio_out = PRESETn ? dout_q : '0;
   assign gpio_oe  = PRESETn ? dir_q  : '0;
   assign irq      = irq_q;

   // transfer FSM: setup latch, wait counting, completion and abort
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      case (state_q)
         ST_IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ST_SETUP;
               cnt_d   = 4'd0;
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
            end
         end
         ST_SETUP, ST_ACCESS: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (PENABLE) begin
               if (access_ready) begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_ACCESS;
                  cnt_d   = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // register updates; writes land only on the completing cycle
   always_comb begin
      dout_d = dout_q;
      dir_d  = dir_q;
      if (commit && reg_sel == REG_DOUT) dout_d = (dout_q & ~bmask) | wbits;
      if (commit && reg_sel == REG_DIR)  dir_d  = (dir_q  & ~bmask) | wbits;
      // a fresh edge overrides a simultaneous W1C clear
      ists_d = ists_q;
      if (commit && reg_sel == REG_INT) ists_d = ists_q & ~wbits;
      ists_d = ists_d | rise;
   end

   // state, registers, synchroniser and irq flop
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         dout_q  <= '0;
         dir_q   <= '0;
         ists_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         dout_q  <= dout_d;
         dir_q   <= dir_d;
         ists_q  <= ists_d;
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         irq_q   <= |ists_q;
      end
   end

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Bench for apb_gpio_slave: APB transfers with a scoreboard of expected
// completions plus direct checks of pins, irq timing and reset behaviour.
module tb_apb_gpio_slave;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [3:0]  PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic [31:0] gpio_in, gpio_out, gpio_oe;
   logic        irq;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   w;

   always #5 PCLK = ~PCLK;

   apb_gpio_slave dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
   endtask

   // one APB transfer; returns with PSEL/PENABLE still high just after the
   // completing edge so a back-to-back setup can follow immediately
   task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd,
                       input logic exp_err, output int waits);
      exp_t e, got;
      bit   done;
      e.wr = wr; e.err = exp_err; e.rdata = exp_rd;
      sb.push_back(e);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      done  = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge PCLK);
         if (PREADY) begin
            got = sb.pop_front();
            chk("pslverr", {31'd0, PSLVERR}, {31'd0, got.err});
            if (got.wr)        chk("prdata_on_write", PRDATA, 32'd0);
            else if (!got.err) chk("prdata", PRDATA, got.rdata);
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge PCLK); #1;
      end
      if (!done) begin
         chk("timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
      PADDR = 4'h0; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; gpio_in = 32'd0;

      // outputs quiet during reset even with a bus access pending
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_pready",  {31'd0, PREADY},  32'd0);
      chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
      chk("rst_prdata",  PRDATA,           32'd0);
      chk("rst_gpio_out", gpio_out,        32'd0);
      chk("rst_gpio_oe",  gpio_oe,         32'd0);
      chk("rst_irq",     {31'd0, irq},     32'd0);
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      // full write, one wait cycle
      xfer(1'b1, 4'h0, 32'h0000_00F0, 4'hF, 32'd0, 1'b0, w);
      chk("wait_cycles", w, 32'd1);
      chk("gpio_out_f0", gpio_out, 32'h0000_00F0);
      idle();

      // byte-strobed write
      xfer(1'b1, 4'h0, 32'hFFFF_FFFF, 4'h5, 32'd0, 1'b0, w);
      idle();
      chk("gpio_out_strb", gpio_out, 32'h00FF_00FF);

      // zero strobes: no change, no error
      xfer(1'b1, 4'h0, 32'h0000_0000, 4'h0, 32'd0, 1'b0, w); idle();
      xfer(1'b0, 4'h0, 32'd0, 4'h0, 32'h00FF_00FF, 1'b0, w); idle();

      // input edge -> status -> irq, checking the latency
      gpio_in = 32'h0000_000F;
      for (int k = 1; k <= 4; k++) begin
         @(posedge PCLK); #1;
         if (k == 3) chk("irq_early", {31'd0, irq}, 32'd0);
         if (k == 4) chk("irq_rise",  {31'd0, irq}, 32'd1);
      end
      xfer(1'b0, 4'h8, 32'd0, 4'h0, 32'h0000_000F, 1'b0, w); idle();
      xfer(1'b0, 4'hC, 32'd0, 4'h0, 32'h0000_000F, 1'b0, w); idle();
      xfer(1'b1, 4'hC, 32'h0000_0003, 4'hF, 32'd0, 1'b0, w); idle();
      xfer(1'b0, 4'hC, 32'd0, 4'h0, 32'h0000_000C, 1'b0, w); idle();
      chk("irq_partial_clr", {31'd0, irq}, 32'd1);

      // error responses leave registers untouched
      xfer(1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, w); idle();
      xfer(1'b0, 4'h1, 32'd0, 4'h0, 32'd0, 1'b1, w); idle();
      xfer(1'b0, 4'h0, 32'd0, 4'h0, 32'h00FF_00FF, 1'b0, w); idle();
      xfer(1'b0, 4'h8, 32'd0, 4'h0, 32'h0000_000F, 1'b0, w); idle();

      // back-to-back write then read
      xfer(1'b1, 4'h4, 32'h0000_000F, 4'hF, 32'd0, 1'b0, w);
      xfer(1'b0, 4'h4, 32'd0, 4'h0, 32'h0000_000F, 1'b0, w);
      idle();
      chk("gpio_oe", gpio_oe, 32'h0000_000F);

      // PENABLE with no setup phase
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 4'h0;
      PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
      @(negedge PCLK);
      chk("proto_pready",  {31'd0, PREADY},  32'd1);
      chk("proto_pslverr", {31'd0, PSLVERR}, 32'd1);
      @(posedge PCLK); #1;
      idle();
      xfer(1'b0, 4'h0, 32'd0, 4'h0, 32'h00FF_00FF, 1'b0, w); idle();

      // abort: PSEL dropped in the access phase
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0;
      PWDATA = 32'h1234_5678; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0;
      @(negedge PCLK);
      chk("abort_pready", {31'd0, PREADY}, 32'd0);
      @(posedge PCLK); #1;
      idle();
      xfer(1'b0, 4'h0, 32'd0, 4'h0, 32'h00FF_00FF, 1'b0, w); idle();

      // clear all status, then a clear racing a new edge: the edge wins
      xfer(1'b1, 4'hC, 32'h0000_000F, 4'hF, 32'd0, 1'b0, w); idle();
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      gpio_in = 32'h0000_001F;
      xfer(1'b1, 4'hC, 32'h0000_0010, 4'hF, 32'd0, 1'b0, w); idle();
      xfer(1'b0, 4'hC, 32'd0, 4'h0, 32'h0000_0010, 1'b0, w); idle();

      // reset during the access phase of a write
      gpio_in = 32'd0;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0;
      PWDATA = 32'hAAAA_5555; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      @(negedge PCLK);
      chk("rst_mid_pready", {31'd0, PREADY}, 32'd0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      chk("post_rst_pready", {31'd0, PREADY}, 32'd0);
      chk("post_rst_gpio_out", gpio_out, 32'd0);
      chk("post_rst_irq", {31'd0, irq}, 32'd0);
      @(posedge PCLK); #1;
      xfer(1'b0, 4'h0, 32'd0, 4'h0, 32'd0, 1'b0, w); idle();
      xfer(1'b0, 4'h8, 32'd0, 4'h0, 32'd0, 1'b0, w); idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
